rpn_eval: RTL

- Reverse-Polish expression evaluator that sits directly upstream of the team's LIFO stack and drives its push/pop/data port.
- Accepts a token stream (operands and ASCII operator codes) over a valid/ready handshake.
- Uses the external stack for operand storage and reports the final result, or a sticky error code.

---
 rtl/rpn_eval.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rpn_eval.sv
// rpn_eval: Reverse-Polish expression evaluator.
// Consumes operand/operator tokens over a valid/ready handshake. It keeps its
// operands in an external LIFO stack through push/pop/data strobes. It reports
// the final result with a one-cycle pulse, or a sticky error code.
module rpn_eval #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid_i,
  output logic             tok_ready_o,
  input  logic             tok_is_op_i,
  input  logic [WIDTH-1:0] tok_data_i,
  output logic             push_o,
  output logic             pop_o,
  output logic [WIDTH-1:0] data_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             full_i,
  input  logic             empty_i,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [1:0]       err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP_B = 3'd1;
  localparam logic [2:0] S_POP_A = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [WIDTH-1:0] TOK_ADD = WIDTH'('h2B);
  localparam logic [WIDTH-1:0] TOK_SUB = WIDTH'('h2D);
  localparam logic [WIDTH-1:0] TOK_MUL = WIDTH'('h2A);
  localparam logic [WIDTH-1:0] TOK_EQ  = WIDTH'('h3D);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_BAD   = 2'd3;

  logic [2:0]       state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Modular arithmetic: every result wraps to WIDTH bits, and a product keeps its low half.
  function automatic logic [WIDTH-1:0] alu_wrap(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (op)
      OP_SUB:  alu_wrap = a - b;
      OP_MUL:  alu_wrap = prod[WIDTH-1:0];
      default: alu_wrap = a + b;
    endcase
  endfunction

  // Next-state logic and decoding of the handshake and stack strobes.
  always_comb begin
    state_d        = state_q;
    err_d          = err_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    push_o         = 1'b0;
    pop_o          = 1'b0;
    data_o         = '0;
    tok_ready_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tok_ready_o = 1'b1;
        if (tok_valid_i) begin
          if (!tok_is_op_i) begin
            if (full_i) begin
              state_d = S_ERR;
              err_d   = ERR_OVER;
            end else begin
              push_o = 1'b1;
              data_o = tok_data_i;
            end
          end else begin
            case (tok_data_i)
              TOK_ADD: begin op_d = OP_ADD; state_d = S_POP_B; end
              TOK_SUB: begin op_d = OP_SUB; state_d = S_POP_B; end
              TOK_MUL: begin op_d = OP_MUL; state_d = S_POP_B; end
              TOK_EQ:  state_d = S_FIN;
              default: begin state_d = S_ERR; err_d = ERR_BAD; end
            endcase
          end
        end
      end
      S_POP_B: begin
        if (empty_i) begin
          state_d = S_ERR;
          err_d   = ERR_UNDER;
        end else begin
          b_d     = data_i;
          pop_o   = 1'b1;
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        if (empty_i) begin
          state_d = S_ERR;
          err_d   = ERR_UNDER;
        end else begin
          a_d     = data_i;
          pop_o   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Two entries were just popped, so this push always has room.
        push_o  = 1'b1;
        data_o  = alu_wrap(op_q, a_q, b_q);
        state_d = S_IDLE;
      end
      S_FIN: begin
        if (empty_i) begin
          state_d = S_ERR;
          err_d   = ERR_UNDER;
        end else begin
          result_d = data_i;
          pop_o    = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        // The stack must be empty after the final pop; leftover operands mean the expression is malformed.
        if (empty_i) begin
          result_valid_d = 1'b1;
          state_d        = S_IDLE;
        end else begin
          state_d = S_ERR;
          err_d   = ERR_BAD;
        end
      end
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; an asynchronous reset aborts any expression in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      err_q          <= ERR_NONE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Operand and opcode holding registers; the state machine qualifies them, so they need no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign err_o          = err_q;

endmodule
